// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage pipeline sequencing controller: load-use stalls, redirect
//            flushes, data-memory freezes, saturating stall/flush counters.
//            Optional build macro: HAZARD_FWD_EN (EX/MEM forwarding present).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [4:0]           ID_rs1_add_i,
    input  logic [4:0]           ID_rs2_add_i,
    input  logic                 ID_rs1_use_i,
    input  logic                 ID_rs2_use_i,
    input  logic [4:0]           EX_rd_add_i,
    input  logic                 EX_reg_write_i,
    input  logic                 EX_mem_rd_en_i,
    input  logic [4:0]           MEM_rd_add_i,
    input  logic                 MEM_reg_write_i,
    input  logic [4:0]           WB_rd_add_i,
    input  logic                 WB_reg_write_i,
    input  logic                 EX_pc_sel_i,
    input  logic                 MEM_req_i,
    input  logic                 dmem_ready_i,
    output logic                 pc_en_o,
    output logic                 if_id_en_o,
    output logic                 id_ex_en_o,
    output logic                 ex_mem_en_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 mem_wb_bubble_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_FLUSH    = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;

    localparam logic [1:0] c_FLUSH_LOAD = 2'(FLUSH_CYCLES);
    localparam bit         c_FLUSH_EN   = (FLUSH_CYCLES > 0);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [1:0]           r_flush_left;
    logic [1:0]           w_flush_left_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_freeze;
    logic w_hazard;
    logic w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem, w_rs1_wb, w_rs2_wb;

    function automatic logic f_match(input logic src_used, input logic [4:0] src,
                                     input logic [4:0] rd, input logic wr_en);
        return src_used & (src == rd) & wr_en & (rd != 5'd0);
    endfunction

    assign w_freeze  = MEM_req_i & ~dmem_ready_i;

    assign w_rs1_ex  = f_match(ID_rs1_use_i, ID_rs1_add_i, EX_rd_add_i,  EX_reg_write_i);
    assign w_rs2_ex  = f_match(ID_rs2_use_i, ID_rs2_add_i, EX_rd_add_i,  EX_reg_write_i);
    assign w_rs1_mem = f_match(ID_rs1_use_i, ID_rs1_add_i, MEM_rd_add_i, MEM_reg_write_i);
    assign w_rs2_mem = f_match(ID_rs2_use_i, ID_rs2_add_i, MEM_rd_add_i, MEM_reg_write_i);
    assign w_rs1_wb  = f_match(ID_rs1_use_i, ID_rs1_add_i, WB_rd_add_i,  WB_reg_write_i);
    assign w_rs2_wb  = f_match(ID_rs2_use_i, ID_rs2_add_i, WB_rd_add_i,  WB_reg_write_i);

`ifdef HAZARD_FWD_EN
    // Forwarding covers every dependency except a load still in EX.
    logic w_unused_fwd;
    assign w_unused_fwd = &{1'b0, w_rs1_mem, w_rs2_mem, w_rs1_wb, w_rs2_wb};
    assign w_hazard     = EX_mem_rd_en_i & (w_rs1_ex | w_rs2_ex);
`else
    // No bypass and no write-through register file: wait until the writer retires.
    logic w_unused_fwd;
    assign w_unused_fwd = &{1'b0, EX_mem_rd_en_i};
    assign w_hazard     = w_rs1_ex | w_rs2_ex | w_rs1_mem | w_rs2_mem | w_rs1_wb | w_rs2_wb;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_ST_RUN;
            r_flush_left <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
        end
    end

    // Next-state logic; a frozen FLUSH holds both state and remaining count
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_left_nxt = r_flush_left;
        case (r_state)
            c_ST_RUN: begin
                if (w_freeze) begin
                    w_state_nxt = c_ST_MEM_WAIT;
                end else if (EX_pc_sel_i && c_FLUSH_EN) begin
                    w_state_nxt      = c_ST_FLUSH;
                    w_flush_left_nxt = c_FLUSH_LOAD;
                end
            end
            c_ST_FLUSH: begin
                if (!w_freeze) begin
                    if (EX_pc_sel_i) begin
                        w_flush_left_nxt = c_FLUSH_LOAD;
                    end else if (r_flush_left <= 2'd1) begin
                        w_flush_left_nxt = 2'd0;
                        w_state_nxt      = c_ST_RUN;
                    end else begin
                        w_flush_left_nxt = r_flush_left - 2'd1;
                    end
                end
            end
            c_ST_MEM_WAIT: begin
                if (!w_freeze) begin
                    if (EX_pc_sel_i && c_FLUSH_EN) begin
                        w_state_nxt      = c_ST_FLUSH;
                        w_flush_left_nxt = c_FLUSH_LOAD;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt      = c_ST_RUN;
                w_flush_left_nxt = 2'd0;
            end
        endcase
    end

    // Output logic (Mealy, priority ordered)
    always_comb begin
        pc_en_o         = 1'b1;
        if_id_en_o      = 1'b1;
        id_ex_en_o      = 1'b1;
        ex_mem_en_o     = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (rst_i) begin
            pc_en_o         = 1'b0;
            if_id_en_o      = 1'b0;
            id_ex_en_o      = 1'b0;
            ex_mem_en_o     = 1'b0;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            mem_wb_bubble_o = 1'b1;
        end else if (w_freeze) begin
            pc_en_o         = 1'b0;
            if_id_en_o      = 1'b0;
            id_ex_en_o      = 1'b0;
            ex_mem_en_o     = 1'b0;
            mem_wb_bubble_o = 1'b1;
        end else if (EX_pc_sel_i || (r_state == c_ST_FLUSH)) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = EX_pc_sel_i;
        end else if (w_hazard) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en_o && (r_stall_cnt != {CNT_WIDTH{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (if_id_flush_o && (r_flush_cnt != {CNT_WIDTH{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire
